disp_arbiter: RTL and testbench
===============================

# disp_arbiter

Time-shares the 8-digit seven-segment display between four requesters, such as the UART transmitter, UART receiver, error counter and switch echo. Each requester offers a 32-bit hex value and 8 decimal-point bits. The arbiter grants the display in round-robin order, snapshots the winner's value and holds it for a guaranteed minimum time. Its registered `digits`/`dp` outputs feed the per-digit and per-decimal-point inputs of the display controller.

## Interface
Parameters:
- `HOLD`, default 50_000_000: minimum display time per grant, in `clk` cycles (1 s at 50 MHz). Legal range is HOLD ≥ 2.
- `CW`, default $clog2(HOLD): width of the hold counter (derived; do not override).

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; one clock; all state changes on rising `clk` edge.
- `req`  in  4  level request per requester; bit i = requester i.
- `data`  in  4×32  packed `[3:0][31:0]`; hex nibbles for digits 7..0 (bits 31:28 = digit 7).
- `dpin`  in  4×8  packed `[3:0][7:0]`; decimal-point bits per requester, passed through unmodified.
- `ack`  out  4  one-cycle grant/capture pulse, one-hot or zero.
- `owner`  out  2  index of the requester currently displayed; meaningful only while `busy`=1.
- `busy`  out  1  high while a hold interval is running.
- `digits`  out  32  captured value driving the display digits.
- `dp`  out  8  captured decimal-point bits.

## Operation
- FSM states are IDLE and SHOW. There is also an internal `last` register (2 bits) and a down-counter `cnt` (CW bits).
- Reset values:
  - state = IDLE, `last` = 3, `cnt` = 0.
  - `ack` = 0, `busy` = 0, `owner` = 0.
  - `digits` = 32'h0000_0000, `dp` = 8'hFF.
- Arbitration picks the first set `req` bit in search order `last`+1, `last`+2, `last`+3, `last`+4 (mod 4). The previous owner therefore has the lowest priority.
- A grant to requester i happens on one edge and does all of the following:
  - load `digits`←`data[i]`, `dp`←`dpin[i]`, `owner`←i, `last`←i;
  - set `ack[i]`=1 for exactly the following cycle;
  - set `busy`=1 and `cnt`←HOLD−1;
  - move state to SHOW.
- IDLE: grant if any `req` bit is set; otherwise stay in IDLE. `digits`/`dp` keep their last values, so the display never blanks.
- SHOW with `cnt`≠0: decrement `cnt`. `req` is ignored and the captured outputs are frozen, even if the owner's `data` changes.
- SHOW with `cnt`=0:
  - if any `req` bit is set, grant immediately (back-to-back, no idle cycle);
  - otherwise go to IDLE, set `busy`=0 and leave `owner` unchanged.
- Requester protocol: hold `req[i]` until `ack[i]` is seen, then drop it within HOLD−1 cycles. A `req[i]` still high when the hold interval expires counts as a new request.
- Asserting `reset` mid-hold returns everything to reset values immediately. After reset is released, arbitration starts from requester 0.

## Timing
- Grant latency from IDLE: `req` high before edge E gives a grant at E. The outputs change right after E, `ack` is high for cycle E→E+1, and `busy` is 1 from E.
- The hold interval is exactly HOLD cycles. Successive grants occur at edges E, E+HOLD, E+2·HOLD, and so on, while requests remain pending.
- A final hold ends at edge E+HOLD: `busy` falls after it when no `req` is set.
- A `req` that rises in the same cycle another one expires competes in that arbitration.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
Run with HOLD=4.
- **Reset:** assert `reset` asynchronously between edges → outputs go immediately to `digits`=0, `dp`=FF, `busy`=0, `ack`=0.
- **Single grant:** `req`=4'b0100, `data[2]`=32'h1234_ABCD, `dpin[2]`=8'hFE; drop `req` after `ack` → `ack`=4'b0100 for one cycle, `digits`=1234_ABCD, `owner`=2. `busy` is high for 4 cycles, then IDLE with `digits` retained.
- **Round-robin fairness:** hold `req`=4'b1111 → `ack` sequence is 0001, 0010, 0100, 1000, 0001, spaced exactly 4 cycles apart, with `busy` never dropping.
- **Snapshot freeze:** during SHOW, change `data[owner]` and raise another requester's `req` → `digits` unchanged until the 4-cycle expiry, and the new request is granted exactly at expiry.
- **Simultaneous requests after a grant:** after requester 1 is served, raise `req`=4'b0011 together → requester 0 is granted before requester 1 (search starts at `last`+1=2).
- **Reset mid-operation:** assert `reset` with `cnt`=2 while `req`=4'b1000 stays high → `busy`=0 immediately. On release, requester 3 is granted on the first edge.

Source files
------------

// File: rtl/disp_arbiter.sv
// disp_arbiter: round-robin time-sharing of the 8-digit display between four
// requesters. The winner's value is snapshotted and held for HOLD cycles.
//
// state | meaning
// IDLE  | no hold running; captured value stays on the display
// SHOW  | hold interval running; cnt counts down to the next arbitration
module disp_arbiter #(
  parameter int HOLD = 50_000_000,
  parameter int CW   = $clog2(HOLD)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [3:0][31:0] data,
  input  logic [3:0][7:0]  dpin,
  output logic [3:0]       ack,
  output logic [1:0]       owner,
  output logic             busy,
  output logic [31:0]      digits,
  output logic [7:0]       dp
);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    last;
  logic [CW-1:0] cnt;
  logic [1:0]    pick;
  logic          found;
  logic          grant;
  logic          expire;

  assign expire = (cnt == '0);

  // Round-robin search starting just after the previous owner.
  always_comb begin
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!found && req[last + 2'(k)]) begin
        found = 1'b1;
        pick  = last + 2'(k);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and grant decision.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant     = 1'b1;
          state_nxt = SHOW;
        end
      end
      SHOW: begin
        if (expire) begin
          if (found) grant     = 1'b1;
          else       state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture, hold counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last   <= 2'd3;
      cnt    <= '0;
      ack    <= '0;
      busy   <= 1'b0;
      owner  <= '0;
      digits <= '0;
      dp     <= 8'hFF;
    end else begin
      ack <= '0;
      if (grant) begin
        digits <= data[pick];
        dp     <= dpin[pick];
        owner  <= pick;
        last   <= pick;
        ack    <= 4'b0001 << pick;
        busy   <= 1'b1;
        cnt    <= CW'(HOLD - 1);
      end else if (state == SHOW) begin
        if (!expire) cnt  <= cnt - CW'(1);
        else         busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_disp_arbiter.sv
// tb_disp_arbiter: directed checks of disp_arbiter with HOLD=4.
module tb_disp_arbiter;

  logic             clk;
  logic             reset;
  logic [3:0]       req;
  logic [3:0][31:0] data;
  logic [3:0][7:0]  dpin;
  logic [3:0]       ack;
  logic [1:0]       owner;
  logic             busy;
  logic [31:0]      digits;
  logic [7:0]       dp;

  int total = 0;
  int bad   = 0;

  disp_arbiter #(.HOLD(4)) dut (
    .clk(clk), .reset(reset), .req(req), .data(data), .dpin(dpin),
    .ack(ack), .owner(owner), .busy(busy), .digits(digits), .dp(dp)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [3:0]  rr_ack [5];
  logic [1:0]  rr_own [5];
  logic [31:0] rr_dig [5];

  // Directed sequence.
  initial begin
    rr_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_own = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rr_dig = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h1111_1111};
    reset = 1'b0;
    req   = '0;
    data[0] = 32'h1111_1111; dpin[0] = 8'h01;
    data[1] = 32'h2222_2222; dpin[1] = 8'h02;
    data[2] = 32'h3333_3333; dpin[2] = 8'h04;
    data[3] = 32'h4444_4444; dpin[3] = 8'h08;

    // Asynchronous reset between edges.
    #2 reset = 1'b1;
    #1;
    chk("rst_digits", digits, 32'h0);
    chk("rst_dp", 32'(dp), 32'hFF);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    step();
    step();
    reset = 1'b0;

    // Round-robin with all requesting.
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      step();
      chk("rr_ack", 32'(ack), 32'(rr_ack[g]));
      chk("rr_owner", 32'(owner), 32'(rr_own[g]));
      chk("rr_digits", digits, rr_dig[g]);
      chk("rr_busy", 32'(busy), 32'h1);
      if (g == 4) req = 4'b0000;
      for (int c = 1; c < 4; c++) begin
        step();
        chk("rr_ack_gap", 32'(ack), 32'h0);
        chk("rr_busy_hold", 32'(busy), 32'h1);
      end
    end
    step();
    chk("rr_busy_end", 32'(busy), 32'h0);

    // Single grant to requester 2.
    data[2] = 32'h1234_ABCD; dpin[2] = 8'hFE;
    req = 4'b0100;
    step();
    chk("sg_ack", 32'(ack), 32'h4);
    chk("sg_digits", digits, 32'h1234_ABCD);
    chk("sg_dp", 32'(dp), 32'hFE);
    chk("sg_owner", 32'(owner), 32'h2);
    chk("sg_busy", 32'(busy), 32'h1);
    req = 4'b0000;
    for (int c = 1; c < 4; c++) begin
      step();
      chk("sg_ack_off", 32'(ack), 32'h0);
      chk("sg_busy_hold", 32'(busy), 32'h1);
    end
    step();
    chk("sg_busy_end", 32'(busy), 32'h0);
    chk("sg_digits_kept", digits, 32'h1234_ABCD);
    chk("sg_dp_kept", 32'(dp), 32'hFE);
    chk("sg_owner_kept", 32'(owner), 32'h2);

    // Snapshot freeze while a new request waits.
    data[0] = 32'hAAAA_0000; dpin[0] = 8'h5A;
    req = 4'b0001;
    step();
    chk("sf_ack", 32'(ack), 32'h1);
    chk("sf_digits", digits, 32'hAAAA_0000);
    req = 4'b0000;
    step();
    data[0] = 32'hBBBB_1111;
    data[1] = 32'hC0DE_0001; dpin[1] = 8'h7F;
    req = 4'b0010;
    chk("sf_frozen1", digits, 32'hAAAA_0000);
    step();
    chk("sf_frozen2", digits, 32'hAAAA_0000);
    chk("sf_ack_wait", 32'(ack), 32'h0);
    step();
    chk("sf_frozen3", digits, 32'hAAAA_0000);
    chk("sf_dp_frozen", 32'(dp), 32'h5A);
    step();
    chk("sf_ack_next", 32'(ack), 32'h2);
    chk("sf_digits_next", digits, 32'hC0DE_0001);
    chk("sf_dp_next", 32'(dp), 32'h7F);
    chk("sf_owner_next", 32'(owner), 32'h1);
    chk("sf_busy_cont", 32'(busy), 32'h1);
    req = 4'b0000;
    for (int c = 1; c < 4; c++) step();
    step();
    chk("sf_busy_end", 32'(busy), 32'h0);

    // Simultaneous requests after requester 1 was served.
    req = 4'b0011;
    step();
    chk("sim_ack0", 32'(ack), 32'h1);
    chk("sim_owner0", 32'(owner), 32'h0);
    chk("sim_digits0", digits, 32'hBBBB_1111);
    req = 4'b0010;
    for (int c = 1; c < 4; c++) step();
    step();
    chk("sim_ack1", 32'(ack), 32'h2);
    chk("sim_owner1", 32'(owner), 32'h1);
    chk("sim_busy1", 32'(busy), 32'h1);
    req = 4'b0000;
    for (int c = 1; c < 4; c++) step();
    step();
    chk("sim_busy_end", 32'(busy), 32'h0);

    // Reset in the middle of a hold.
    req = 4'b1000;
    step();
    chk("mr_ack", 32'(ack), 32'h8);
    chk("mr_digits", digits, 32'h4444_4444);
    step();
    chk("mr_busy_pre", 32'(busy), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_digits_rst", digits, 32'h0);
    chk("mr_dp_rst", 32'(dp), 32'hFF);
    chk("mr_owner_rst", 32'(owner), 32'h0);
    step();
    chk("mr_busy_held", 32'(busy), 32'h0);
    chk("mr_ack_held", 32'(ack), 32'h0);
    reset = 1'b0;
    step();
    chk("mr_ack_rel", 32'(ack), 32'h8);
    chk("mr_owner_rel", 32'(owner), 32'h3);
    chk("mr_busy_rel", 32'(busy), 32'h1);
    chk("mr_digits_rel", digits, 32'h4444_4444);
    chk("mr_dp_rel", 32'(dp), 32'h08);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
